// File: rtl/dm_bus_pkg.sv
// rtl/dm_bus_pkg.sv - shared types and response codes for the data-memory bus master
package dm_bus_pkg;

  // Transaction FSM states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } dm_state_e;

  // Bus response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/dm_bus_master.sv
// rtl/dm_bus_master.sv - MEM-stage data-memory master onto AR/R/AW/W/B bus channels
//
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   DM_MEM_access/WEB/... : MEM-stage request (WEB 1=read, DM_write byte enables active low)
//   IM_stall              : pipeline frozen by fetch; holds the FSM in DONE
//   DM_out, DM_stall      : registered load data, pipeline freeze
//   AR*/R*/AW*/W*/B*      : bus channels
//   dm_bus_err            : sticky error flag (only when DM_BUS_ERR_EN is defined)
// Optional feature macro: DM_BUS_ERR_EN
module dm_bus_master
  import dm_bus_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_MEM_access,
  input  logic              DM_WEB,
  input  logic [3:0]        DM_write,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [31:0]       DM_data_in,
  input  logic              IM_stall,
  output logic [31:0]       DM_out,
  output logic              DM_stall,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [31:0]       RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic              dm_bus_err
);

  dm_state_e state, state_nxt;
  logic      aw_done, w_done;
  logic      flushed;   // request withdrawn while the bus transaction was in flight
  logic      aw_ok, w_ok, abort;

  // Each write channel counts as complete once its own handshake has happened,
  // whether in an earlier cycle (flag) or this one.
  assign aw_ok = aw_done | (AWVALID & AWREADY);
  assign w_ok  = w_done  | (WVALID & WREADY);
  // A withdrawn request must not be acknowledged by this completion.
  assign abort = flushed | ~DM_MEM_access;

  assign RREADY   = (state == RD_D);
  assign BREADY   = (state == WR_B);
  assign DM_stall = DM_MEM_access & (state != DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      ARVALID <= 1'b0;
      AWVALID <= 1'b0;
      WVALID  <= 1'b0;
      ARADDR  <= '0;
      AWADDR  <= '0;
      WDATA   <= '0;
      WSTRB   <= '0;
      DM_out  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      flushed <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          flushed <= 1'b0;
          if (DM_MEM_access) begin
            ARADDR <= DM_addr;
            AWADDR <= DM_addr;
            WDATA  <= DM_data_in;
            WSTRB  <= ~DM_write;
            if (DM_WEB) begin
              ARVALID <= 1'b1;
            end else begin
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (ARREADY) ARVALID <= 1'b0;
        end
        RD_D: begin
          if (RVALID) DM_out <= RDATA;
        end
        WR_A: begin
          if (AWVALID && AWREADY) begin
            AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (WVALID && WREADY) begin
            WVALID <= 1'b0;
            w_done <= 1'b1;
          end
        end
        default: ;
      endcase
      if ((state inside {RD_A, RD_D, WR_A, WR_B}) && !DM_MEM_access) flushed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (DM_MEM_access) state_nxt = DM_WEB ? RD_A : WR_A;
      RD_A: if (ARREADY) state_nxt = RD_D;
      RD_D: if (RVALID) state_nxt = abort ? IDLE : DONE;
      WR_A: if (aw_ok && w_ok) state_nxt = WR_B;
      WR_B: if (BVALID) state_nxt = abort ? IDLE : DONE;
      DONE: state_nxt = IM_stall ? DONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DM_BUS_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      dm_bus_err <= 1'b0;
    end else if ((RVALID && RREADY && (RRESP != OKAY)) ||
                 (BVALID && BREADY && (BRESP != OKAY))) begin
      dm_bus_err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{RRESP, BRESP};
  assign dm_bus_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dm_bus_master.sv
// tb/tb_dm_bus_master.sv - directed self-checking bench for dm_bus_master
module tb_dm_bus_master;
  import dm_bus_pkg::*;

`ifdef DM_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        DM_MEM_access, DM_WEB, IM_stall;
  logic [3:0]  DM_write;
  logic [31:0] DM_addr, DM_data_in, DM_out;
  logic        DM_stall;
  logic [31:0] ARADDR, AWADDR, WDATA, RDATA;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [1:0]  RRESP, BRESP;
  logic [3:0]  WSTRB;
  logic        dm_bus_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dm_bus_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .DM_MEM_access(DM_MEM_access), .DM_WEB(DM_WEB), .DM_write(DM_write),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .IM_stall(IM_stall),
    .DM_out(DM_out), .DM_stall(DM_stall),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dm_bus_err(dm_bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = OKAY;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = OKAY;
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    tests++;
    if ({ARVALID, AWVALID, WVALID, RREADY, BREADY} !== 5'b0) begin
      fails++; $display("FAIL reset_handshake got %b want 00000", {ARVALID, AWVALID, WVALID, RREADY, BREADY});
    end
    tests++;
    if ({DM_out, WSTRB, ARADDR, AWADDR, WDATA} !== '0) begin
      fails++; $display("FAIL reset_data DM_out=%h WSTRB=%b ARADDR=%h AWADDR=%h WDATA=%h want 0", DM_out, WSTRB, ARADDR, AWADDR, WDATA);
    end
    tests++;
    if (dm_bus_err !== 1'b0 || DM_stall !== 1'b0) begin
      fails++; $display("FAIL reset_flags err=%b stall=%b want 0 0", dm_bus_err, DM_stall);
    end
    rst = 1;
    tick();
  endtask

  task automatic test_read();
    int stalls = 0;
    slave_idle();
    ARREADY = 1; RVALID = 1; RDATA = 32'hDEADBEEF;
    DM_MEM_access = 1; DM_WEB = 1; DM_addr = 32'h0000_1000; DM_write = 4'hF;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (DM_stall !== 1'b1) break;
      stalls++;
      if (stalls == 2) begin
        tests++;
        if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_1000) begin
          fails++; $display("FAIL read_ar ARVALID=%b ARADDR=%h want 1 00001000", ARVALID, ARADDR);
        end
      end
      if (stalls == 3) begin
        tests++;
        if (RREADY !== 1'b1 || ARVALID !== 1'b0) begin
          fails++; $display("FAIL read_r RREADY=%b ARVALID=%b want 1 0", RREADY, ARVALID);
        end
      end
      tick();
    end
    tests++;
    if (stalls != 3) begin
      fails++; $display("FAIL read_latency stall cycles %0d want 3", stalls);
    end
    tests++;
    if (DM_out !== 32'hDEADBEEF || DM_stall !== 1'b0 || dut.state !== DONE) begin
      fails++; $display("FAIL read_data DM_out=%h stall=%b want deadbeef 0 DONE", DM_out, DM_stall);
    end
    slave_idle();
    DM_MEM_access = 0;
    tick();
  endtask

  task automatic test_write_split();
    slave_idle();
    DM_MEM_access = 1; DM_WEB = 0; DM_write = 4'b1101;
    DM_data_in = 32'h0000AB00; DM_addr = 32'h0000_2000;
    tick();
    tests++;
    if (WSTRB !== 4'b0010 || WDATA !== 32'h0000AB00 || AWADDR !== 32'h0000_2000 || AWVALID !== 1'b1 || WVALID !== 1'b1) begin
      fails++; $display("FAIL wr_req WSTRB=%b WDATA=%h AWADDR=%h AWV=%b WV=%b want 0010 0000ab00 00002000 1 1",
                        WSTRB, WDATA, AWADDR, AWVALID, WVALID);
    end
    AWREADY = 1;
    tick();
    AWREADY = 0;
    tests++;
    if (AWVALID !== 1'b0 || WVALID !== 1'b1 || dut.state !== WR_A) begin
      fails++; $display("FAIL wr_aw_only AWV=%b WV=%b want 0 1 in WR_A", AWVALID, WVALID);
    end
    tick();
    tests++;
    if (dut.state !== WR_A || WVALID !== 1'b1) begin
      fails++; $display("FAIL wr_wait_w state=%0d WV=%b want WR_A 1", dut.state, WVALID);
    end
    WREADY = 1;
    tick();
    WREADY = 0;
    tests++;
    if (dut.state !== WR_B || WVALID !== 1'b0 || BREADY !== 1'b1) begin
      fails++; $display("FAIL wr_b state=%0d WV=%b BREADY=%b want WR_B 0 1", dut.state, WVALID, BREADY);
    end
    BVALID = 1;
    tick();
    BVALID = 0;
    tests++;
    if (dut.state !== DONE || DM_stall !== 1'b0 || DM_out !== 32'hDEADBEEF) begin
      fails++; $display("FAIL wr_done state=%0d stall=%b DM_out=%h want DONE 0 deadbeef", dut.state, DM_stall, DM_out);
    end
    DM_MEM_access = 0;
    tick();
  endtask

  task automatic test_im_stall();
    slave_idle();
    ARREADY = 1; RVALID = 1; RDATA = 32'h12345678;
    IM_stall = 1;
    DM_MEM_access = 1; DM_WEB = 1; DM_addr = 32'h0000_1004;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (dut.state !== DONE || DM_stall !== 1'b0 || ARVALID !== 1'b0) begin
        fails++; $display("FAIL im_stall_hold cyc %0d state=%0d stall=%b ARV=%b want DONE 0 0", i, dut.state, DM_stall, ARVALID);
      end
      if (i == 3) begin
        IM_stall = 0; DM_MEM_access = 0;
      end
      tick();
    end
    tests++;
    if (dut.state !== IDLE || ARVALID !== 1'b0 || DM_out !== 32'h12345678) begin
      fails++; $display("FAIL im_stall_release state=%0d ARV=%b DM_out=%h want IDLE 0 12345678", dut.state, ARVALID, DM_out);
    end
    slave_idle();
  endtask

  task automatic test_reset_mid();
    slave_idle();
    ARREADY = 1;
    DM_MEM_access = 1; DM_WEB = 1; DM_addr = 32'h0000_5000;
    tick(); tick();
    tests++;
    if (dut.state !== RD_D || RREADY !== 1'b1) begin
      fails++; $display("FAIL rstmid_setup state=%0d RREADY=%b want RD_D 1", dut.state, RREADY);
    end
    rst = 0;
    tick();
    tests++;
    if (ARVALID !== 1'b0 || RREADY !== 1'b0 || DM_out !== 32'h0 || dut.state !== IDLE) begin
      fails++; $display("FAIL rstmid ARV=%b RREADY=%b DM_out=%h state=%0d want 0 0 0 IDLE", ARVALID, RREADY, DM_out, dut.state);
    end
    rst = 1; DM_MEM_access = 0; slave_idle();
    tick();
  endtask

  task automatic test_flush();
    slave_idle();
    DM_MEM_access = 1; DM_WEB = 1; DM_addr = 32'h0000_3000;
    tick();
    DM_MEM_access = 0;
    tick();
    DM_MEM_access = 1; DM_WEB = 0; DM_write = 4'b0000;
    DM_data_in = 32'h55AA55AA; DM_addr = 32'h0000_4000;
    #1;
    tests++;
    if (DM_stall !== 1'b1 || ARVALID !== 1'b1 || dut.state !== RD_A) begin
      fails++; $display("FAIL flush_busy stall=%b ARV=%b state=%0d want 1 1 RD_A", DM_stall, ARVALID, dut.state);
    end
    ARREADY = 1;
    tick();
    ARREADY = 0; RVALID = 1; RDATA = 32'hCAFEF00D;
    tick();
    RVALID = 0;
    tests++;
    if (dut.state !== IDLE || DM_stall !== 1'b1 || AWVALID !== 1'b0) begin
      fails++; $display("FAIL flush_to_idle state=%0d stall=%b AWV=%b want IDLE 1 0", dut.state, DM_stall, AWVALID);
    end
    tick();
    tests++;
    if (dut.state !== WR_A || AWVALID !== 1'b1 || WVALID !== 1'b1 || WSTRB !== 4'hF || AWADDR !== 32'h0000_4000) begin
      fails++; $display("FAIL flush_new_write state=%0d AWV=%b WV=%b WSTRB=%b AWADDR=%h want WR_A 1 1 1111 00004000",
                        dut.state, AWVALID, WVALID, WSTRB, AWADDR);
    end
    AWREADY = 1; WREADY = 1;
    tick();
    tests++;
    if (dut.state !== WR_B) begin
      fails++; $display("FAIL wr_same_cycle state=%0d want WR_B", dut.state);
    end
    AWREADY = 0; WREADY = 0; BVALID = 1;
    tick();
    BVALID = 0; DM_MEM_access = 0;
    tick();
  endtask

  task automatic quick_write(input logic [1:0] resp);
    slave_idle();
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = resp;
    DM_MEM_access = 1; DM_WEB = 0; DM_write = 4'h0; DM_addr = 32'h0000_6000;
    tick(); tick(); tick();
    DM_MEM_access = 0; slave_idle();
    tick();
  endtask

  task automatic test_bus_err();
    quick_write(SLVERR);
    tests++;
    if (dm_bus_err !== ERR_EN) begin
      fails++; $display("FAIL bus_err_set got %b want %b", dm_bus_err, ERR_EN);
    end
    quick_write(OKAY);
    tests++;
    if (dm_bus_err !== ERR_EN) begin
      fails++; $display("FAIL bus_err_sticky got %b want %b", dm_bus_err, ERR_EN);
    end
  endtask

  initial begin
    rst = 0; IM_stall = 0;
    DM_MEM_access = 0; DM_WEB = 1; DM_write = 4'hF; DM_addr = 0; DM_data_in = 0;
    slave_idle();
    test_reset();
    test_read();
    test_write_split();
    test_im_stall();
    test_reset_mid();
    test_flush();
    test_bus_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
